// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for a two-port register-file write path.
// Port A carries ALU results and port B carries load/multi-cycle results.
// One request wins per cycle and is registered onto the we3/wa3/wd3 write
// port. A busy scoreboard tracks destinations reserved by issued
// multi-cycle ops, and read-hazard flags are derived from it.
module rf_wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        hold,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic [31:0] busy,
    output logic        hazard1,
    output logic        hazard2
);

    // last_grant: 1 = port B won the most recent acceptance
    logic        last_grant_q, last_grant_d;
    logic        we3_q, we3_d;
    logic [4:0]  wa3_q, wa3_d;
    logic [31:0] wd3_q, wd3_d;
    logic [31:0] busy_q, busy_d;
    logic        a_acc, b_acc;

    // Grant decode: purely from valids, hold and the pointer; reset blocks grants
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset_n && !hold) begin
            if (a_valid && b_valid) begin
                if (RR_EN && !last_grant_q) begin
                    b_ready = 1'b1;
                end else begin
                    a_ready = 1'b1;
                end
            end else if (a_valid) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    // Next-state: pointer, write port and scoreboard
    always_comb begin
        a_acc        = a_valid && a_ready;
        b_acc        = b_valid && b_ready;
        last_grant_d = last_grant_q;
        we3_d        = 1'b0;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        busy_d       = busy_q;

        if (a_acc) begin
            last_grant_d = 1'b0;
        end else if (b_acc) begin
            last_grant_d = 1'b1;
        end

        // x0 is hardwired: the handshake completes but nothing is written
        if (a_acc && (a_addr != 5'd0)) begin
            we3_d = 1'b1;
            wa3_d = a_addr;
            wd3_d = a_data;
        end else if (b_acc && (b_addr != 5'd0)) begin
            we3_d = 1'b1;
            wa3_d = b_addr;
            wd3_d = b_data;
        end

        // Clear first so a same-cycle reservation of the same register wins
        if (b_acc) begin
            busy_d[b_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != 5'd0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any pending write and favours A next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            we3_q        <= 1'b0;
            wa3_q        <= 5'd0;
            wd3_q        <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            busy_q       <= busy_d;
        end
    end

    // Hazard: outstanding reservation, or the write landing this cycle
    always_comb begin
        hazard1 = (ra1 != 5'd0) && (busy_q[ra1] || (we3_q && (wa3_q == ra1)));
        hazard2 = (ra2 != 5'd0) && (busy_q[ra2] || (we3_q && (wa3_q == ra2)));
    end

    assign we3  = we3_q;
    assign wa3  = wa3_q;
    assign wd3  = wd3_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a round-robin instance carries the scoreboarded
// traffic; a fixed-priority instance shares its inputs for grant checks.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, b_valid, hold, rsv_valid;
    logic [4:0]  a_addr, b_addr, rsv_addr, ra1, ra2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, we3, hazard1, hazard2;
    logic [4:0]  wa3;
    logic [31:0] wd3, busy;
    logic        fp_a_ready, fp_b_ready, fp_we3, fp_hazard1, fp_hazard2;
    logic [4:0]  fp_wa3;
    logic [31:0] fp_wd3, fp_busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .hold(hold), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .ra1(ra1), .ra2(ra2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    rf_wb_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(fp_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(fp_b_ready),
        .hold(hold), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .ra1(ra1), .ra2(ra2),
        .we3(fp_we3), .wa3(fp_wa3), .wd3(fp_wd3), .busy(fp_busy),
        .hazard1(fp_hazard1), .hazard2(fp_hazard2)
    );

    typedef struct packed {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        hold;
        logic        rv;
        logic [4:0]  rsva;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference model: scoreboard bits, who won last, and the write-port view
    logic [31:0] m_busy;
    bit          m_last_b;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit haz(input logic [4:0] r);
        return (r != 5'd0) && (m_busy[r] || (m_we && (m_wa == r)));
    endfunction

    task automatic model_reset();
        m_busy   = 32'd0;
        m_last_b = 1'b1;
        m_we     = 1'b0;
        m_wa     = 5'd0;
        m_wd     = 32'd0;
        exp_q.delete();
    endtask

    // One cycle: drive at the falling edge, check combinational outputs,
    // then advance the model to the state after the coming rising edge.
    task automatic step(input stim_t s, output bit ga, output bit gb);
        bit ea, eb, fa, fb;
        @(negedge clk);
        a_valid = s.av;  a_addr = s.aa;  a_data = s.ad;
        b_valid = s.bv;  b_addr = s.ba;  b_data = s.bd;
        hold = s.hold;   rsv_valid = s.rv; rsv_addr = s.rsva;
        ra1 = s.r1;      ra2 = s.r2;
        #1;
        ea = 1'b0; eb = 1'b0;
        if (!s.hold) begin
            if (s.av && s.bv) begin
                if (m_last_b) ea = 1'b1; else eb = 1'b1;
            end else if (s.av) ea = 1'b1;
            else if (s.bv) eb = 1'b1;
        end
        fa = !s.hold && s.av;
        fb = !s.hold && !s.av && s.bv;
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        chk("fp_a_ready", 32'(fp_a_ready), 32'(fa));
        chk("fp_b_ready", 32'(fp_b_ready), 32'(fb));
        chk("hazard1", 32'(hazard1), 32'(haz(s.r1)));
        chk("hazard2", 32'(hazard2), 32'(haz(s.r2)));
        chk("busy", busy, m_busy);
        m_we = 1'b0;
        if (ea) begin
            m_last_b = 1'b0;
            if (s.aa != 5'd0) begin
                m_we = 1'b1; m_wa = s.aa; m_wd = s.ad;
                exp_q.push_back({s.aa, s.ad});
            end
        end
        if (eb) begin
            m_last_b = 1'b1;
            m_busy[s.ba] = 1'b0;
            if (s.ba != 5'd0) begin
                m_we = 1'b1; m_wa = s.ba; m_wd = s.bd;
                exp_q.push_back({s.ba, s.bd});
            end
        end
        if (s.rv && (s.rsva != 5'd0)) m_busy[s.rsva] = 1'b1;
        ga = ea;
        gb = eb;
    endtask

    // Monitor: every expected write must appear on the port one cycle later
    always @(negedge clk) begin
        wr_t e;
        if (reset_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_we3", 32'(we3), 32'd1);
                chk("wb_wa3", 32'(wa3), 32'(e.addr));
                chk("wb_wd3", wd3, e.data);
            end else begin
                chk("idle_we3", 32'(we3), 32'd0);
                chk("idle_wa3_hold", 32'(wa3), 32'(m_wa));
                chk("idle_wd3_hold", wd3, m_wd);
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        bit ga, gb, pa, pb;
        logic [4:0]  paa, pba;
        logic [31:0] pad, pbd;

        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        hold = 0; rsv_valid = 0; rsv_addr = 0; ra1 = 0; ra2 = 0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #2 a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_busy", busy, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;

        // A alone writes 0xDEADBEEF to x5, one-cycle pulse
        s = '0; s.av = 1; s.aa = 5'd5; s.ad = 32'hDEADBEEF;
        step(s, ga, gb);
        chk("a_alone_ready", 32'(a_ready), 32'd1);
        s = '0; step(s, ga, gb);
        chk("a_alone_we3", 32'(we3), 32'd1);
        chk("a_alone_wa3", 32'(wa3), 32'd5);
        chk("a_alone_wd3", wd3, 32'hDEADBEEF);
        s = '0; step(s, ga, gb);
        chk("a_alone_we3_off", 32'(we3), 32'd0);

        // Continuous contention after reset: RR alternates A,B; fixed gives A
        pulse_reset();
        pad = 32'h0000_A000; pbd = 32'h0000_B000;
        for (int i = 0; i < 4; i++) begin
            s = '0; s.av = 1; s.aa = 5'd3; s.ad = pad; s.bv = 1; s.ba = 5'd7; s.bd = pbd;
            step(s, ga, gb);
            chk("rr_order_a", 32'(a_ready), 32'((i % 2) == 0));
            chk("rr_order_b", 32'(b_ready), 32'((i % 2) == 1));
            chk("fp_order_a", 32'(fp_a_ready), 32'd1);
            chk("fp_order_b", 32'(fp_b_ready), 32'd0);
            if (ga) pad = pad + 1;
            if (gb) pbd = pbd + 1;
        end
        s = '0; s.av = 1; s.aa = 5'd3; s.ad = pad; step(s, ga, gb);
        s = '0; step(s, ga, gb);

        // Reservation of x9 held until the B write three cycles later
        s = '0; s.rv = 1; s.rsva = 5'd9; s.r1 = 5'd9; step(s, ga, gb);
        s = '0; s.r1 = 5'd9; step(s, ga, gb);
        chk("rsv9_haz_a", 32'(hazard1), 32'd1);
        step(s, ga, gb);
        chk("rsv9_busy", busy, 32'h0000_0200);
        s = '0; s.r1 = 5'd9; s.bv = 1; s.ba = 5'd9; s.bd = 32'h9999_0009; step(s, ga, gb);
        chk("rsv9_haz_b", 32'(hazard1), 32'd1);
        s = '0; s.r1 = 5'd9; step(s, ga, gb);
        chk("rsv9_busy_clr", busy, 32'd0);
        chk("rsv9_haz_we3", 32'(hazard1), 32'd1);
        step(s, ga, gb);
        chk("rsv9_haz_gone", 32'(hazard1), 32'd0);

        // Same-cycle set and clear of x9: set wins; x0 reservation ignored
        s = '0; s.rv = 1; s.rsva = 5'd9; s.bv = 1; s.ba = 5'd9; s.bd = 32'h0000_0999;
        step(s, ga, gb);
        s = '0; step(s, ga, gb);
        chk("setclr_busy9", 32'(busy[9]), 32'd1);
        s = '0; s.bv = 1; s.ba = 5'd9; s.bd = 32'h0000_1999; step(s, ga, gb);
        s = '0; s.rv = 1; s.rsva = 5'd0; step(s, ga, gb);
        s = '0; step(s, ga, gb);
        chk("rsv0_busy", busy, 32'd0);

        // Write to x0 completes without we3; hold blocks both grants
        s = '0; s.av = 1; s.aa = 5'd0; s.ad = 32'h0000_1234; step(s, ga, gb);
        chk("x0_a_ready", 32'(a_ready), 32'd1);
        s = '0; s.hold = 1; s.av = 1; s.aa = 5'd4; s.ad = 32'h44; s.bv = 1; s.ba = 5'd6; s.bd = 32'h66;
        step(s, ga, gb);
        chk("x0_we3", 32'(we3), 32'd0);
        chk("hold_a_ready", 32'(a_ready), 32'd0);
        chk("hold_b_ready", 32'(b_ready), 32'd0);
        s.hold = 0; step(s, ga, gb);
        chk("hold_we3", 32'(we3), 32'd0);
        if (ga) s.av = 0;
        if (gb) s.bv = 0;
        step(s, ga, gb);
        s = '0; step(s, ga, gb);

        // Reset mid-cycle with a write in flight and x9 busy
        s = '0; s.rv = 1; s.rsva = 5'd9; step(s, ga, gb);
        s = '0; s.av = 1; s.aa = 5'd3; s.ad = 32'hCAFE_0003; step(s, ga, gb);
        @(posedge clk);
        #2;
        chk("pre_rst_we3", 32'(we3), 32'd1);
        chk("pre_rst_busy", busy, 32'h0000_0200);
        a_valid = 1'b1; b_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_we3", 32'(we3), 32'd0);
        chk("mid_rst_wa3", 32'(wa3), 32'd0);
        chk("mid_rst_wd3", wd3, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        s = '0; step(s, ga, gb);
        chk("post_rst_we3", 32'(we3), 32'd0);
        s = '0; s.av = 1; s.aa = 5'd1; s.ad = 32'h11; s.bv = 1; s.ba = 5'd2; s.bd = 32'h22;
        step(s, ga, gb);
        chk("post_rst_first_a", 32'(a_ready), 32'd1);
        chk("post_rst_first_b", 32'(b_ready), 32'd0);
        s.av = 0; step(s, ga, gb);

        // Randomized traffic; requesters hold their request until accepted
        pa = 0; pb = 0; paa = 0; pba = 0; pad = 0; pbd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1; paa = 5'($urandom_range(0, 31)); pad = $urandom;
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1; pba = 5'($urandom_range(0, 31)); pbd = $urandom;
            end
            s = '0;
            s.av = pa; s.aa = paa; s.ad = pad;
            s.bv = pb; s.ba = pba; s.bd = pbd;
            s.hold = ($urandom_range(0, 7) == 0);
            s.rv   = ($urandom_range(0, 3) == 0);
            s.rsva = 5'($urandom_range(0, 31));
            s.r1   = 5'($urandom_range(0, 31));
            s.r2   = 5'($urandom_range(0, 31));
            step(s, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        for (int i = 0; i < 4 && (pa || pb); i++) begin
            s = '0;
            s.av = pa; s.aa = paa; s.ad = pad;
            s.bv = pb; s.ba = pba; s.bd = pbd;
            step(s, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        s = '0; step(s, ga, gb);
        step(s, ga, gb);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, port A always wins.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  ALU write-back request valid.
REQ-005 a_addr  input  5  ALU destination register.
REQ-006 a_data  input  32  ALU result.
REQ-007 a_ready  output  1  ALU request accepted this cycle.
REQ-008 b_valid  input  1  load/multi-cycle unit write-back request valid.
REQ-009 b_addr  input  5  load/multi-cycle destination register.
REQ-010 b_data  input  32  load/multi-cycle result.
REQ-011 b_ready  output  1  load/multi-cycle request accepted this cycle.
REQ-012 hold  input  1  freeze grants, e.g. for a pipeline stall.
REQ-013 rsv_valid  input  1  reserve a destination for an issued multi-cycle op.
REQ-014 rsv_addr  input  5  register to reserve.
REQ-015 ra1, ra2  input  5 each  read addresses to hazard-check.
REQ-016 we3  output  1  register-file write enable.
REQ-017 wa3  output  5  register-file write address.
REQ-018 wd3  output  32  register-file write data.
REQ-019 busy  output  32  scoreboard; bit i = register i has a write outstanding.
REQ-020 hazard1, hazard2  output  1 each  read of ra1/ra2 would return stale data.

Function
REQ-021 Handshake: a request is accepted in the cycle where its valid and ready are both 1.
REQ-022 Handshake: the requester holds valid, addr and data stable until accepted.
REQ-023 Grants: at most one of a_ready/b_ready is 1 per cycle; both are 0 whenever hold=1.
REQ-024 Grants: a_ready/b_ready are combinational from valids, hold and the arbitration pointer; they never depend on the other port's ready.
REQ-025 Single requester valid (hold=0): that requester is granted.
REQ-026 Both valid, RR_EN=1: the port not granted last is granted; 1-bit last_grant pointer updates only on acceptance.
REQ-027 Both valid, RR_EN=0: A is granted.
REQ-028 Write latency: an acceptance at edge N drives we3=1, wa3=addr, wd3=data for cycle N..N+1; the register file commits at edge N+1.
REQ-029 Idle: with no acceptance, we3=0 next cycle; wa3/wd3 hold their last values.
REQ-030 Register 0: an accepted request with addr=0 completes the handshake but leaves we3=0.
REQ-031 Scoreboard set: rsv_valid=1 with rsv_addr!=0 sets busy[rsv_addr] at the edge.
REQ-032 Scoreboard: rsv_addr=0 is ignored; busy[0] is always 0.
REQ-033 Scoreboard clear: a B acceptance clears busy[b_addr] at the edge.
REQ-034 Scoreboard: A acceptances never clear busy.
REQ-035 Set and clear of the same register in one cycle: set wins and the bit stays 1.
REQ-036 Reserving an already-busy register leaves it 1; there is no count or error.
REQ-037 hazard1 = (ra1!=0) AND (busy[ra1] OR (we3 AND wa3==ra1)); hazard2 is the same for ra2.
REQ-038 Hazard outputs are purely combinational.

Reset
REQ-039 reset_n=0 immediately forces we3=0, wa3=0, wd3=0, busy=0 and last_grant=B, so A wins the first contention.
REQ-040 A write pending at reset assertion is discarded and no we3 pulse follows reset release.
REQ-041 While reset_n=0, a_ready and b_ready are 0.

Verification
REQ-042 Bench shall cover: A alone, addr=5, data=0xDEADBEEF, accepted at edge N -> we3=1, wa3=5, wd3=0xDEADBEEF in cycle after N; we3=0 next cycle.
REQ-043 Bench shall cover: A and B both valid continuously for 4 cycles after reset, RR_EN=1 -> grant order A,B,A,B; RR_EN=0 -> A four times, B never.
REQ-044 Bench shall cover: rsv addr=9, then B write to 9 three cycles later -> busy[9]=1 until the B acceptance edge; hazard1 with ra1=9 stays 1 through the we3 cycle, then 0.
REQ-045 Bench shall cover: same cycle rsv_addr=9 and B acceptance addr=9 -> busy[9]=1 afterwards; rsv_addr=0 -> busy stays 0.
REQ-046 Bench shall cover: A addr=0 data=0x1234 -> a_ready=1, we3 stays 0; hold=1 with both valid -> no ready, we3=0 next cycle.
REQ-047 Bench shall cover: reset_n low mid-cycle with a write pending and busy=0x00000200 -> outputs zero immediately; no we3 after release; next contention grants A.
